iomem_arbiter2: RTL

//  Shares one PicoSoC iomem slave port (GPIO/peripheral space, addr[31:24]==8'h03) between two masters.
//  m0 is the CPU iomem port; m1 is a secondary master (UART debug bridge or DMA).

---
 rtl/iomem_pkg.sv | 17 +
 rtl/iomem_arbiter2_if.sv | 14 +
 rtl/iomem_rr_arb2.sv | 13 +
 rtl/iomem_arbiter2.sv | 119 +++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// Shared constants and request type for the PicoSoC iomem arbiter family.
package iomem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] IOMEM_ERR_RDATA = 32'hBADC_0FFE;
    localparam logic [7:0]  GPIO_BASE_HI    = 8'h03;

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iomem_req_t;

endpackage

// File: rtl/iomem_arbiter2_if.sv
// One PicoSoC iomem port; master drives the request, slave answers with ready/rdata.
interface iomem_arbiter2_if;

    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);

endinterface

// File: rtl/iomem_rr_arb2.sv
// Combinational two-way round-robin pick; a lone requester always wins.
module iomem_rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,  // 1: requester 1 wins a tie
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/iomem_arbiter2.sv
// Two-master round-robin arbiter onto one iomem slave port, with a bus watchdog
// so a slave that never answers cannot hang either master.
module iomem_arbiter2
    import iomem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = IOMEM_ERR_RDATA
) (
    input  logic             CLKOUT,
    input  logic             resetn,
    iomem_arbiter2_if.slave  m0,
    iomem_arbiter2_if.slave  m1,
    iomem_arbiter2_if.master s,
    output logic [1:0]       grant,
    output logic             timeout_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             prio_q, prio_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    iomem_req_t       req_q, req_d;
    logic [1:0][31:0] rdata_q, rdata_d;
    logic             timeout_q, timeout_d;

    logic [1:0]  req;
    logic [1:0]  pick;
    logic        cap;
    logic [31:0] cap_data;

    assign req = {m1.valid, m0.valid};

    iomem_rr_arb2 u_rr (
        .req  (req),
        .prio (prio_q),
        .gnt  (pick)
    );

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        timeout_d = 1'b0;
        cap       = 1'b0;
        cap_data  = s.rdata;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    req_d   = pick[1] ? {m1.wstrb, m1.addr, m1.wdata}
                                      : {m0.wstrb, m0.addr, m0.wdata};
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s.ready) begin
                    cap     = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cap       = 1'b1;
                    cap_data  = ERR_RDATA;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                // The master just served loses the next tie.
                prio_d  = grant_q[0];
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        for (int i = 0; i < 2; i++) begin
            if (cap && grant_q[i]) rdata_d[i] = cap_data;
        end
    end

    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            grant_q   <= '0;
            req_q     <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            req_q     <= req_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    // Ready is a pure decode of DONE, so it lasts exactly one cycle.
    assign s.valid     = (state_q == ST_BUSY);
    assign s.wstrb     = req_q.wstrb;
    assign s.addr      = req_q.addr;
    assign s.wdata     = req_q.wdata;
    assign m0.ready    = (state_q == ST_DONE) & grant_q[0];
    assign m1.ready    = (state_q == ST_DONE) & grant_q[1];
    assign m0.rdata    = rdata_q[0];
    assign m1.rdata    = rdata_q[1];
    assign grant       = grant_q;
    assign timeout_err = timeout_q;

endmodule
